// File: rtl/pu_cfg_pkg.sv
// Shared types and constants for the ProtectionUnit configuration sequencer.
package pu_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_B    = 3'd2,
        ST_AR   = 3'd3,
        ST_R    = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BRESP   = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] PU_CFG    = 8'h00;
    localparam logic [7:0] PU_STATUS = 8'h04;
    localparam logic [7:0] PU_POLICY = 8'h40;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/pu_config_sequencer.sv
// AXI4-Lite master issuing one register write per command, with optional
// readback compare; halts with a sticky error code on the first failure.
//
// state | meaning
// IDLE  | waiting for a command (ready only when no error is pending)
// WR    | AW and W in flight, each retired on its own handshake
// B     | waiting for write response
// AR    | read address in flight (verify only)
// R     | waiting for readback data
// DONE  | one-cycle completion pulse
// ERR   | halted until err_clr
module pu_config_sequencer
    import pu_cfg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              m00_axi_aclk,
    input  logic              m00_axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_verify,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] m00_axi_awaddr,
    output logic              m00_axi_awvalid,
    input  logic              m00_axi_awready,
    output logic [DATA_W-1:0] m00_axi_wdata,
    output logic [3:0]        m00_axi_wstrb,
    output logic              m00_axi_wvalid,
    input  logic              m00_axi_wready,
    input  logic [1:0]        m00_axi_bresp,
    input  logic              m00_axi_bvalid,
    output logic              m00_axi_bready,
    output logic [ADDR_W-1:0] m00_axi_araddr,
    output logic              m00_axi_arvalid,
    input  logic              m00_axi_arready,
    input  logic [DATA_W-1:0] m00_axi_rdata,
    input  logic [1:0]        m00_axi_rresp,
    input  logic              m00_axi_rvalid,
    output logic              m00_axi_rready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] rd_data
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [TMR_W-1:0]  r_tmr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_verify;
    logic              r_cmd_ready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_err;

    logic w_aw_done;
    logic w_w_done;
    logic w_timeout;
    logic w_unused;

    assign w_aw_done = !r_awvalid || m00_axi_awready;
    assign w_w_done  = !r_wvalid || m00_axi_wready;
    assign w_timeout = (r_tmr == TMR_LAST);
    assign w_unused  = &{1'b0, cmd_addr[1:0], m00_axi_bresp[0], m00_axi_rresp[0]};

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_verify    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            // Timer restarts on every state entry; wait paths below override.
            r_tmr  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        r_wdata     <= cmd_data;
                        r_verify    <= cmd_verify;
                        r_busy      <= 1'b1;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_state     <= ST_WR;
                    end else begin
                        r_cmd_ready <= (r_err == ERR_NONE);
                    end
                end
                ST_WR: begin
                    if (w_aw_done && w_w_done) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_B;
                    end else if (w_timeout) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= ERR_TIMEOUT;
                        r_state   <= ST_ERR;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                        if (r_awvalid && m00_axi_awready) r_awvalid <= 1'b0;
                        if (r_wvalid && m00_axi_wready) r_wvalid <= 1'b0;
                    end
                end
                ST_B: begin
                    if (m00_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m00_axi_bresp[1]) begin
                            r_busy  <= 1'b0;
                            r_err   <= ERR_BRESP;
                            r_state <= ST_ERR;
                        end else if (r_verify) begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_bready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_err    <= ERR_TIMEOUT;
                        r_state  <= ST_ERR;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_AR: begin
                    if (m00_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end else if (w_timeout) begin
                        r_arvalid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_err     <= ERR_TIMEOUT;
                        r_state   <= ST_ERR;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_R: begin
                    if (m00_axi_rvalid) begin
                        r_rready  <= 1'b0;
                        r_rd_data <= m00_axi_rdata;
                        r_busy    <= 1'b0;
                        if (m00_axi_rresp[1] || (m00_axi_rdata != r_wdata)) begin
                            r_err   <= ERR_VERIFY;
                            r_state <= ST_ERR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        r_rready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_err    <= ERR_TIMEOUT;
                        r_state  <= ST_ERR;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (err_clr) begin
                        r_err   <= ERR_NONE;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign m00_axi_awaddr  = r_addr;
    assign m00_axi_awvalid = r_awvalid;
    assign m00_axi_wdata   = r_wdata;
    assign m00_axi_wstrb   = 4'hF;
    assign m00_axi_wvalid  = r_wvalid;
    assign m00_axi_bready  = r_bready;
    assign m00_axi_araddr  = r_addr;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err_code        = r_err;
    assign rd_data         = r_rd_data;

endmodule

// File: tb/tb_pu_config_sequencer.sv
// Directed and randomized checks of the configuration sequencer against a
// delay-programmable AXI-Lite slave and a cycle-count reference model.
module tb_pu_config_sequencer;
    import pu_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_verify = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  m00_axi_awaddr;
    logic        m00_axi_awvalid;
    logic        m00_axi_awready;
    logic [31:0] m00_axi_wdata;
    logic [3:0]  m00_axi_wstrb;
    logic        m00_axi_wvalid;
    logic        m00_axi_wready;
    logic [1:0]  m00_axi_bresp;
    logic        m00_axi_bvalid;
    logic        m00_axi_bready;
    logic [7:0]  m00_axi_araddr;
    logic        m00_axi_arvalid;
    logic        m00_axi_arready;
    logic [31:0] m00_axi_rdata;
    logic [1:0]  m00_axi_rresp;
    logic        m00_axi_rvalid;
    logic        m00_axi_rready;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [31:0] rd_data;

    pu_config_sequencer #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_verify(cmd_verify), .err_clr(err_clr),
        .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awvalid(m00_axi_awvalid),
        .m00_axi_awready(m00_axi_awready), .m00_axi_wdata(m00_axi_wdata),
        .m00_axi_wstrb(m00_axi_wstrb), .m00_axi_wvalid(m00_axi_wvalid),
        .m00_axi_wready(m00_axi_wready), .m00_axi_bresp(m00_axi_bresp),
        .m00_axi_bvalid(m00_axi_bvalid), .m00_axi_bready(m00_axi_bready),
        .m00_axi_araddr(m00_axi_araddr), .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_arready(m00_axi_arready), .m00_axi_rdata(m00_axi_rdata),
        .m00_axi_rresp(m00_axi_rresp), .m00_axi_rvalid(m00_axi_rvalid),
        .m00_axi_rready(m00_axi_rready), .busy(busy), .done(done),
        .err_code(err_code), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Slave configuration, programmed by the stimulus between commands.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [31:0] cfg_rdata = '0;

    logic        aw_got, w_got, b_on, r_on;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          ar_count = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    logic [7:0]  p_awaddr, p_araddr, cap_awaddr, cap_araddr;
    logic [31:0] p_wdata, cap_wdata;

    // Slave acts on falling edges; a handshake is inferred from the
    // valid/ready pair that was presented across the preceding rising edge.
    always @(negedge clk) begin
        if (!aresetn) begin
            m00_axi_awready = 1'b0; m00_axi_wready = 1'b0; m00_axi_arready = 1'b0;
            m00_axi_bvalid = 1'b0; m00_axi_rvalid = 1'b0;
            m00_axi_bresp = RESP_OKAY; m00_axi_rresp = RESP_OKAY; m00_axi_rdata = '0;
            aw_got = 0; w_got = 0; b_on = 0; r_on = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        end else begin
            if (p_awv && p_awr) begin aw_got = 1; cap_awaddr = p_awaddr; end
            if (p_wv && p_wr) begin w_got = 1; cap_wdata = p_wdata; end
            if (aw_got && w_got && !b_on) begin b_on = 1; b_cnt = 0; end
            if (p_bv && p_br) begin
                b_on = 0; aw_got = 0; w_got = 0; m00_axi_bvalid = 1'b0;
            end else if (b_on) begin
                m00_axi_bvalid = (b_cnt >= b_dly); b_cnt++;
            end
            m00_axi_bresp = cfg_bresp;
            if (p_arv && p_arr) begin
                r_on = 1; r_cnt = 0; cap_araddr = p_araddr; ar_count++;
            end
            if (p_rv && p_rr) begin
                r_on = 0; m00_axi_rvalid = 1'b0;
            end else if (r_on) begin
                m00_axi_rvalid = (r_cnt >= r_dly); r_cnt++;
            end
            m00_axi_rdata = cfg_rdata;
            m00_axi_rresp = cfg_rresp;
            if (!m00_axi_awvalid) begin aw_cnt = 0; m00_axi_awready = (aw_dly == 0); end
            else begin m00_axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
            if (!m00_axi_wvalid) begin w_cnt = 0; m00_axi_wready = (w_dly == 0); end
            else begin m00_axi_wready = (w_cnt >= w_dly); w_cnt++; end
            if (!m00_axi_arvalid) begin ar_cnt = 0; m00_axi_arready = (ar_dly == 0); end
            else begin m00_axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
            p_awv = m00_axi_awvalid; p_awr = m00_axi_awready; p_awaddr = m00_axi_awaddr;
            p_wv = m00_axi_wvalid; p_wr = m00_axi_wready; p_wdata = m00_axi_wdata;
            p_bv = m00_axi_bvalid; p_br = m00_axi_bready;
            p_arv = m00_axi_arvalid; p_arr = m00_axi_arready; p_araddr = m00_axi_araddr;
            p_rv = m00_axi_rvalid; p_rr = m00_axi_rready;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_valids"}, 64'({m00_axi_awvalid, m00_axi_wvalid, m00_axi_arvalid}), 64'd0);
        chk({tag, "_readies"}, 64'({m00_axi_bready, m00_axi_rready}), 64'd0);
        chk({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
        chk({tag, "_err"}, 64'(err_code), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_addr_data"}, {24'd0, m00_axi_awaddr, m00_axi_wdata}, 64'd0);
        chk({tag, "_araddr"}, 64'(m00_axi_araddr), 64'd0);
        chk({tag, "_wstrb"}, 64'(m00_axi_wstrb), 64'hF);
    endtask

    task automatic do_reset();
        aresetn = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
    endtask

    // Presents a command, waits (bounded) for it to be taken, then drops valid.
    task automatic issue(input logic [7:0] a, input logic [31:0] d, input bit v);
        int n;
        cmd_addr = a; cmd_data = d; cmd_verify = v; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        chk("cmd_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // lat counts cycles with the accepting cycle as 1; ends on done or error.
    task automatic run_cmd(input logic [7:0] a, input logic [31:0] d, input bit v,
                           output int lat, output int aw_lat, output int w_lat, output int b_lat);
        issue(a, d, v);
        lat = 2; aw_lat = 0; w_lat = 0; b_lat = 0;
        while (done !== 1'b1 && err_code === 2'd0 && lat < 300) begin
            if (aw_lat == 0 && m00_axi_awvalid === 1'b0) aw_lat = lat;
            if (w_lat == 0 && m00_axi_wvalid === 1'b0) w_lat = lat;
            if (b_lat == 0 && m00_axi_bready === 1'b1) b_lat = lat;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    int          lat, aw_lat, w_lat, b_lat, ar_before, exp_lat, n, mx;
    logic [31:0] exp_rd, rdd;
    logic [7:0]  ra;
    logic [1:0]  exp_err;
    bit          rv, berr, rerr, mism, flag;

    initial begin
        exp_rd = '0;
        #2 chk_reset("reset");
        set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Verified write, zero-wait slave
        set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'hF0F0F0F0);
        ar_before = ar_count;
        run_cmd(PU_CFG, 32'hF0F0F0F0, 1, lat, aw_lat, w_lat, b_lat);
        chk("t1_latency", 64'(lat), 64'd6);
        chk("t1_aw_w_same", 64'(aw_lat), 64'(w_lat));
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_err", 64'(err_code), 64'd0);
        chk("t1_rd_data", 64'(rd_data), 64'hF0F0F0F0);
        chk("t1_ar_count", 64'(ar_count - ar_before), 64'd1);
        chk("t1_wdata", 64'(cap_wdata), 64'hF0F0F0F0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 64'({done, busy}), 64'd0);
        chk("t1_ready_gap", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("t1_ready_back", 64'(cmd_ready), 64'd1);

        // Reset while waiting for read data
        set_slave(0, 0, 0, 0, 8, RESP_OKAY, RESP_OKAY, 32'hA5A50001);
        issue(PU_POLICY + 8'h10, 32'hA5A50001, 1);
        n = 0;
        while (m00_axi_rready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("t6_in_R", 64'(m00_axi_rready), 64'd1);
        #2 aresetn = 1'b0;
        #1 chk_reset("t6_async");
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0000BEEF);
        run_cmd(PU_POLICY + 8'h08, 32'h0000BEEF, 1, lat, aw_lat, w_lat, b_lat);
        chk("t6_after_lat", 64'(lat), 64'd6);
        chk("t6_after_rd", 64'({err_code, rd_data}), 64'h0000BEEF);

        // Write-only with awready delayed; err_clr held to show it is ignored
        set_slave(3, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
        ar_before = ar_count;
        err_clr = 1'b1;
        run_cmd(PU_POLICY, 32'h0000002C, 0, lat, aw_lat, w_lat, b_lat);
        err_clr = 1'b0;
        chk("t2_latency", 64'(lat), 64'd7);
        chk("t2_w_first", 64'(w_lat < aw_lat), 64'd1);
        chk("t2_no_ar", 64'(ar_count - ar_before), 64'd0);
        chk("t2_done", 64'({done, err_code}), 64'h4);
        chk("t2_awaddr", 64'(cap_awaddr), 64'h40);
        repeat (2) @(posedge clk); #1;
        chk("t2_ready_back", 64'(cmd_ready), 64'd1);

        // Verified write to read-only status
        set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
        run_cmd(PU_STATUS, 32'h12345678, 1, lat, aw_lat, w_lat, b_lat);
        chk("t3_err", 64'(err_code), 64'(ERR_VERIFY));
        chk("t3_rd_data", 64'(rd_data), 64'd0);
        chk("t3_no_done", 64'({done, busy}), 64'd0);
        flag = 0;
        cmd_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (cmd_ready !== 1'b0 || err_code !== ERR_VERIFY) flag = 1;
        end
        cmd_valid = 1'b0;
        chk("t3_held", 64'(flag), 64'd0);
        clear_err();
        chk("t3_cleared", 64'(err_code), 64'd0);
        set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h00000077);
        run_cmd(PU_POLICY + 8'h04, 32'h00000077, 1, lat, aw_lat, w_lat, b_lat);
        chk("t3_next_cmd", 64'({done, err_code}), 64'h4);

        // Error write response
        set_slave(0, 0, 0, 0, 0, RESP_SLVERR, RESP_OKAY, 32'h0);
        ar_before = ar_count;
        run_cmd(PU_POLICY + 8'h0C, 32'h00C0FFEE, 1, lat, aw_lat, w_lat, b_lat);
        chk("t4_err", 64'(err_code), 64'(ERR_BRESP));
        chk("t4_no_done", 64'(done), 64'd0);
        chk("t4_no_ar", 64'(ar_count - ar_before), 64'd0);
        clear_err();

        // Write response arrives only after the timeout has fired
        set_slave(0, 0, 20, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
        run_cmd(PU_CFG, 32'h00000001, 0, lat, aw_lat, w_lat, b_lat);
        chk("t5_err", 64'(err_code), 64'(ERR_TIMEOUT));
        chk("t5_b_wait", 64'(lat - b_lat), 64'd15);
        flag = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (m00_axi_bready !== 1'b0 || err_code !== ERR_TIMEOUT || busy !== 1'b0) flag = 1;
        end
        chk("t5_late_b_ignored", 64'(flag), 64'd0);
        do_reset();
        exp_rd = '0;

        // Randomized commands against the latency/outcome model
        for (int i = 0; i < 24; i++) begin
            ra = (i % 3 == 0) ? PU_CFG : (PU_POLICY + 8'($urandom_range(0, 15) * 4));
            ra = ra | 8'($urandom_range(0, 3));
            rdd = $urandom;
            rv = 1'($urandom_range(0, 1));
            berr = ($urandom_range(0, 7) == 0);
            rerr = ($urandom_range(0, 7) == 0);
            mism = ($urandom_range(0, 4) == 0);
            set_slave($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      berr ? ($urandom_range(0, 1) ? RESP_SLVERR : RESP_DECERR)
                           : ($urandom_range(0, 1) ? RESP_OKAY : RESP_EXOKAY),
                      rerr ? RESP_SLVERR : RESP_OKAY,
                      mism ? (rdd ^ (32'h1 << $urandom_range(0, 31))) : rdd);
            exp_err = berr ? ERR_BRESP : ((rv && (rerr || mism)) ? ERR_VERIFY : ERR_NONE);
            mx = (aw_dly > w_dly) ? aw_dly : w_dly;
            exp_lat = 4 + mx + b_dly + ((rv && !berr) ? (2 + ar_dly + r_dly) : 0);
            ar_before = ar_count;
            run_cmd(ra, rdd, rv, lat, aw_lat, w_lat, b_lat);
            if (rv && !berr) exp_rd = cfg_rdata;
            chk("rnd_latency", 64'(lat), 64'(exp_lat));
            chk("rnd_err", 64'(err_code), 64'(exp_err));
            chk("rnd_done", 64'(done), 64'(exp_err == ERR_NONE));
            chk("rnd_rd_data", 64'(rd_data), 64'(exp_rd));
            chk("rnd_awaddr", 64'(cap_awaddr), 64'(ra & 8'hFC));
            chk("rnd_wdata", 64'(cap_wdata), 64'(rdd));
            chk("rnd_ar_count", 64'(ar_count - ar_before), 64'(rv && !berr));
            if (rv && !berr) chk("rnd_araddr", 64'(cap_araddr), 64'(ra & 8'hFC));
            if (err_code !== 2'd0) clear_err();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of stimulus, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pu_config_sequencer.md
Name: pu_config_sequencer

Overview:
- AXI4-Lite master that sequences configuration of the ProtectionUnit register file: config register at 0x00, status at 0x04, policy registers from 0x40.
- Accepts one command at a time on a valid/ready port, issues the AXI-Lite write, and optionally reads back and compares.
- Stops on the first error and reports it.
- Sits between the boot/management logic and the ProtectionUnit's s00_axi config slave, replacing the VIP config master used in simulation.

Parameters:
- ADDR_W, 8, width of register byte address.
- DATA_W, 32, AXI-Lite data width; only 32 is supported.
- TIMEOUT, 1023, max cycles waited for any single AXI handshake; timer width is clog2(TIMEOUT+1).

Ports:
- m00_axi_aclk  in  1  clock; all logic on rising edge.
- m00_axi_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_W  register byte address; bits [1:0] ignored, driven as 0.
- cmd_data  in  DATA_W  write data.
- cmd_verify  in  1  1 = read back after write and compare.
- err_clr  in  1  clears sticky error and returns to IDLE.
- m00_axi_awaddr  out  ADDR_W  write address.
- m00_axi_awvalid / m00_axi_awready  out/in  1  AW handshake.
- m00_axi_wdata  out  DATA_W  write data.
- m00_axi_wstrb  out  4  constant 4'hF.
- m00_axi_wvalid / m00_axi_wready  out/in  1  W handshake.
- m00_axi_bresp  in  2  write response.
- m00_axi_bvalid / m00_axi_bready  in/out  1  B handshake.
- m00_axi_araddr  out  ADDR_W  read address (= latched cmd_addr).
- m00_axi_arvalid / m00_axi_arready  out/in  1  AR handshake.
- m00_axi_rdata  in  DATA_W  read data.
- m00_axi_rresp  in  2  read response.
- m00_axi_rvalid / m00_axi_rready  in/out  1  R handshake.
- busy  out  1  high from command acceptance until done or error.
- done  out  1  one-cycle pulse on successful completion.
- err_code  out  2  0 none, 1 SLVERR/DECERR on B, 2 readback mismatch or bad rresp, 3 timeout; sticky.
- rd_data  out  DATA_W  last readback value.

Behaviour:
- Reset (async assert, sync release): state IDLE. All valid/ready outputs 0, busy 0, done 0, err_code 0, rd_data 0, address/data regs 0.
- IDLE: cmd_ready = (err_code==0). On handshake: latch addr/data/verify, busy=1, assert awvalid and wvalid in the next cycle, go to WR.
- WR: awvalid and wvalid are tracked independently. Each deasserts on its own handshake; either may complete first or both in the same cycle. When both are done, go to B with bready=1.
- B: on bvalid, drop bready. If bresp[1]=1, set err_code=1 and go to ERR. Otherwise go to AR if verify, else DONE.
- AR: arvalid held until arready, then rready=1 and go to R.
- R: on rvalid, drop rready and latch rd_data. If rresp[1] or rdata != latched data, set err_code=2 and go to ERR. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
  - cmd_ready is low in DONE, so the next command is accepted 2 cycles after done at the earliest.
- Minimum latency with zero-wait slave: write-only command = 4 cycles from acceptance to done; with verify = 6.
- Timeout: a counter resets on every state entry and increments while WR, B, AR or R wait. On reaching TIMEOUT: err_code=3, all valids/readies drop, go to ERR.
  - A late response after a timeout is ignored; bready/rready stay 0.
- ERR: busy=0, cmd_ready=0. err_clr clears err_code and goes to IDLE. err_clr is ignored in every other state.
- Valid outputs never drop before their handshake, except on timeout or reset. Address/data are stable while valid is asserted.
- Reset mid-transaction aborts immediately with no completion; the slave must also be in reset.

Decomposition:
- Package pu_cfg_pkg: state enum (IDLE, WR, B, AR, R, DONE, ERR), err_code localparams (ERR_NONE, ERR_BRESP, ERR_VERIFY, ERR_TIMEOUT), register offsets (PU_CFG=0x00, PU_STATUS=0x04, PU_POLICY=0x40), AXI resp constants.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write 0x00 = 0xF0F0F0F0 with verify, zero-wait slave -> AW/W in the same cycle, one B, one AR; rd_data=0xF0F0F0F0; done 6 cycles after acceptance; err_code=0.
- Write 0x40 = 0x0000002C without verify; slave delays awready 3 cycles and wready 0 -> W completes first, no AR issued, done pulse, cmd_ready back high.
- Verify write to read-only status 0x04 = 0x12345678 returning 0 -> err_code=2; cmd_ready stays 0 until err_clr; then a new command is accepted.
- Slave returns bresp=2'b10 -> err_code=1, no AR issued, done not pulsed.
- Slave never asserts bvalid, TIMEOUT=15 -> err_code=3 exactly 15 cycles after entering B; a bvalid arriving later is not acknowledged.
- Assert aresetn low during R -> all outputs return to reset values asynchronously; the first command after release completes normally.
